mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 214 +++++++++++++++++++++
 tb/tb_mem_access.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage with a simple req/ack bus master.
// Non-memory ops pass straight through to MEM/WB. Loads and stores stall the
// pipeline while a single bus transaction runs (IDLE -> BUSY -> DONE).
// Optional feature: define MISALIGN_CHECK_EN to reject misaligned half/word
// accesses with a mem_err pulse instead of issuing them.
module mem_access #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_reg_waddr,
  input  logic        mem_we,
  input  logic [31:0] mem_reg_wdata,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_sdata,
  input  logic [5:0]  stall,
  output logic [4:0]  wb_reg_waddr,
  output logic        wb_we,
  output logic [31:0] wb_reg_wdata,
  output logic        stallreq_mem,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        mem_err
);
  localparam int CW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        mem_err_q, mem_err_d;
  // per-transaction context kept for lane extraction and the DONE write-back
  logic        ld_q, ld_d, err_q, err_d, uns_q, uns_d;
  logic [1:0]  size_q, size_d, off_q, off_d;

  logic        is_ld, is_st, is_mem, misal;
  logic [1:0]  sz;
  logic [3:0]  sel_c;
  logic [31:0] wdata_c, ld_ext;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // only the MEM/WB hold bit matters to this stage
  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[3:0]};

  // opcode decode, byte-lane select and store-data replication
  always_comb begin
    is_ld  = mem_op[3];
    is_st  = mem_op[2] & ~mem_op[3];
    is_mem = is_ld | is_st;
    sz     = mem_op[1:0];
    case (sz)
      2'd0: begin
        sel_c   = 4'b0001 << mem_reg_wdata[1:0];
        wdata_c = {4{mem_sdata[7:0]}};
      end
      2'd1: begin
        // halves pick their lane from addr[1] only
        sel_c   = mem_reg_wdata[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{mem_sdata[15:0]}};
      end
      default: begin
        sel_c   = 4'b1111;
        wdata_c = mem_sdata;
      end
    endcase
`ifdef MISALIGN_CHECK_EN
    misal = ((sz == 2'd1) && mem_reg_wdata[0]) ||
            (sz[1] && (mem_reg_wdata[1:0] != 2'b00));
`else
    misal = 1'b0;
`endif
  end

  // pull the addressed lane out of the read word and extend it
  always_comb begin
    case (off_q)
      2'd0:    lane_b = bus_rdata[7:0];
      2'd1:    lane_b = bus_rdata[15:8];
      2'd2:    lane_b = bus_rdata[23:16];
      default: lane_b = bus_rdata[31:24];
    endcase
    lane_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      2'd0:    ld_ext = uns_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'd1:    ld_ext = uns_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: ld_ext = bus_rdata;
    endcase
  end

  // next-state, bus register updates and MEM/WB outputs
  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_sel_d    = bus_sel_q;
    bus_wdata_d  = bus_wdata_q;
    result_d     = result_q;
    cnt_d        = cnt_q;
    mem_err_d    = 1'b0;
    ld_d         = ld_q;
    err_d        = err_q;
    uns_d        = uns_q;
    size_d       = size_q;
    off_d        = off_q;
    wb_reg_waddr = mem_reg_waddr;
    wb_we        = mem_we;
    wb_reg_wdata = mem_reg_wdata;
    stallreq_mem = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mem) begin
          stallreq_mem = 1'b1;
          wb_we        = 1'b0;
          wb_reg_wdata = 32'b0;
          ld_d         = is_ld;
          uns_d        = is_ld & mem_op[2];
          size_d       = sz;
          off_d        = mem_reg_wdata[1:0];
          cnt_d        = '0;
          err_d        = 1'b0;
          if (misal) begin
            mem_err_d = 1'b1;
            err_d     = 1'b1;
            state_d   = DONE;
          end else begin
            bus_req_d   = 1'b1;
            bus_we_d    = is_st;
            bus_addr_d  = {mem_reg_wdata[31:2], 2'b00};
            bus_sel_d   = sel_c;
            bus_wdata_d = wdata_c;
            state_d     = BUSY;
          end
        end
      end
      BUSY: begin
        stallreq_mem = 1'b1;
        wb_we        = 1'b0;
        wb_reg_wdata = 32'b0;
        cnt_d        = cnt_q + 1'b1;
        // an ack in the same cycle as the timeout still completes the access
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (ld_q) result_d = ld_ext;
          state_d = DONE;
        end else if (cnt_q == CW'(BUS_TIMEOUT - 1)) begin
          bus_req_d = 1'b0;
          mem_err_d = 1'b1;
          err_d     = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        wb_we        = mem_we & ld_q & ~err_q;
        wb_reg_wdata = (ld_q && !err_q) ? result_q : 32'b0;
        if (!stall[4]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and bus registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'b0;
      bus_sel_q   <= 4'b0;
      bus_wdata_q <= 32'b0;
      result_q    <= 32'b0;
      cnt_q       <= '0;
      mem_err_q   <= 1'b0;
      ld_q        <= 1'b0;
      err_q       <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b0;
      off_q       <= 2'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      mem_err_q   <= mem_err_d;
      ld_q        <= ld_d;
      err_q       <= err_d;
      uns_q       <= uns_d;
      size_q      <= size_d;
      off_q       <= off_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_sel   = bus_sel_q;
  assign bus_wdata = bus_wdata_q;
  assign mem_err   = mem_err_q;
endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: pass-through table, load/store
// transactions with a queue of expected write-back data, timeout, stall hold,
// reset mid-transaction and the misalignment option.
module tb_mem_access;
  logic        clk, rst;
  logic [4:0]  mem_reg_waddr, wb_reg_waddr;
  logic        mem_we, wb_we, stallreq_mem;
  logic [31:0] mem_reg_wdata, mem_sdata, wb_reg_wdata;
  logic [3:0]  mem_op, bus_sel;
  logic [5:0]  stall;
  logic        bus_req, bus_we, bus_ack, mem_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  mem_access #(.BUS_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .mem_reg_waddr(mem_reg_waddr), .mem_we(mem_we), .mem_reg_wdata(mem_reg_wdata),
    .mem_op(mem_op), .mem_sdata(mem_sdata), .stall(stall),
    .wb_reg_waddr(wb_reg_waddr), .wb_we(wb_we), .wb_reg_wdata(wb_reg_wdata),
    .stallreq_mem(stallreq_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // One load/store through the stage; ack_lat = BUSY cycles before ack (<0: never).
  task automatic mem_txn(input string nm, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [31:0] rd, input int ack_lat,
                         input logic [31:0] exp_d, input logic exp_we, input logic exp_err,
                         input logic exp_bwe, input logic [3:0] exp_sel,
                         input logic [31:0] exp_bw, input int exp_stall, input int hold);
    int stall_n;
    bit done, bubble_bad, bus_seen;
    logic [31:0] e;
    exp_q.push_back(exp_d);
    @(posedge clk); #1;
    mem_op = op; mem_reg_wdata = addr; mem_sdata = sd; mem_we = 1'b1;
    mem_reg_waddr = 5'd9; bus_rdata = rd; stall = '0; bus_ack = 1'b0;
    stall_n = 0; done = 0; bubble_bad = 0; bus_seen = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!stallreq_mem) begin done = 1; break; end
      stall_n++;
      if (wb_we) bubble_bad = 1;
      if (bus_req) begin
        if (!bus_seen) begin
          chk({nm, " bus_addr"}, bus_addr, {addr[31:2], 2'b00});
          chk({nm, " bus_sel"}, {28'b0, bus_sel}, {28'b0, exp_sel});
          chk({nm, " bus_we"}, {31'b0, bus_we}, {31'b0, exp_bwe});
          if (exp_bwe) chk({nm, " bus_wdata"}, bus_wdata, exp_bw);
        end
        bus_seen = 1;
        if (ack_lat >= 0 && c - 1 >= ack_lat) bus_ack = 1'b1;
      end
    end
    bus_ack = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: stall never released within 400 cycles", nm);
    end
    e = exp_q.pop_front();
    chk({nm, " stall_cycles"}, stall_n, exp_stall);
    chk({nm, " bus_req_seen"}, {31'b0, bus_seen}, {31'b0, exp_stall != 1});
    chk({nm, " bubble_we"}, {31'b0, bubble_bad}, 32'd0);
    chk({nm, " wb_reg_wdata"}, wb_reg_wdata, e);
    chk({nm, " wb_we"}, {31'b0, wb_we}, {31'b0, exp_we});
    chk({nm, " wb_reg_waddr"}, {27'b0, wb_reg_waddr}, 32'd9);
    chk({nm, " mem_err"}, {31'b0, mem_err}, {31'b0, exp_err});
    for (int h = 0; h < hold; h++) begin
      stall = 6'b010000;
      @(negedge clk);
      chk({nm, " hold stallreq"}, {31'b0, stallreq_mem}, 32'd0);
      chk({nm, " hold wdata"}, wb_reg_wdata, e);
      chk({nm, " hold mem_err"}, {31'b0, mem_err}, 32'd0);
    end
    stall = '0;
    @(posedge clk); #1;
    mem_op = 4'b0; mem_we = 1'b0;
    @(negedge clk);
    chk({nm, " after mem_err"}, {31'b0, mem_err}, 32'd0);
    chk({nm, " after bus_req"}, {31'b0, bus_req}, 32'd0);
    chk({nm, " after stallreq"}, {31'b0, stallreq_mem}, 32'd0);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp_wdata;
    logic        exp_we;
  } pt_vec_t;

  pt_vec_t pt[4];

  initial begin
    pt[0] = '{4'b0000, 5'd5,  1'b1, 32'h0000_1234, 32'h0000_1234, 1'b1};
    pt[1] = '{4'b0000, 5'd31, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    pt[2] = '{4'b0011, 5'd1,  1'b1, 32'h8000_0001, 32'h8000_0001, 1'b1};
    pt[3] = '{4'b0010, 5'd17, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};

    rst = 1'b0; mem_reg_waddr = '0; mem_we = 1'b0; mem_reg_wdata = '0; mem_op = '0;
    mem_sdata = '0; stall = '0; bus_rdata = '0; bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst bus_addr", bus_addr, 32'd0);
    chk("rst bus_sel", {28'b0, bus_sel}, 32'd0);
    chk("rst mem_err", {31'b0, mem_err}, 32'd0);
    rst = 1'b1;

    // non-memory pass-through
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      mem_op = pt[i].op; mem_reg_waddr = pt[i].waddr; mem_we = pt[i].we;
      mem_reg_wdata = pt[i].wdata;
      @(negedge clk);
      chk($sformatf("pt%0d wdata", i), wb_reg_wdata, pt[i].exp_wdata);
      chk($sformatf("pt%0d we", i), {31'b0, wb_we}, {31'b0, pt[i].exp_we});
      chk($sformatf("pt%0d waddr", i), {27'b0, wb_reg_waddr}, {27'b0, pt[i].waddr});
      chk($sformatf("pt%0d stallreq", i), {31'b0, stallreq_mem}, 32'd0);
      chk($sformatf("pt%0d bus_req", i), {31'b0, bus_req}, 32'd0);
    end

    //       name    op       addr          sdata         rdata        lat data          we  err bwe sel      bwdata        stall hold
    mem_txn("LB",   4'b1000, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 32'hFFFF_FF80, 1, 0, 0, 4'b1000, 32'h0,        2, 0);
    mem_txn("LBU",  4'b1100, 32'h0000_0101, 32'h0,        32'h0000_A500, 0, 32'h0000_00A5, 1, 0, 0, 4'b0010, 32'h0,        2, 0);
    mem_txn("LH",   4'b1001, 32'h0000_0100, 32'h0,        32'h1234_F00D, 1, 32'hFFFF_F00D, 1, 0, 0, 4'b0011, 32'h0,        3, 0);
    mem_txn("LHU",  4'b1101, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 0, 32'h0000_8001, 1, 0, 0, 4'b1100, 32'h0,        2, 2);
    mem_txn("LW",   4'b1010, 32'h0000_0200, 32'h0,        32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 1, 0, 0, 4'b1111, 32'h0,        5, 0);
    mem_txn("SH",   4'b0101, 32'h0000_0102, 32'h0000_ABCD, 32'h0,        0, 32'h0,         0, 0, 1, 4'b1100, 32'hABCD_ABCD, 2, 0);
    mem_txn("SB",   4'b0100, 32'h0000_0101, 32'h0000_005A, 32'h0,        0, 32'h0,         0, 0, 1, 4'b0010, 32'h5A5A_5A5A, 2, 0);
    mem_txn("SW",   4'b0110, 32'h0000_0204, 32'h1234_5678, 32'h0,        2, 32'h0,         0, 0, 1, 4'b1111, 32'h1234_5678, 4, 1);
    mem_txn("LWTO", 4'b1010, 32'h0000_0300, 32'h0,        32'h5555_5555, -1, 32'h0,        0, 1, 0, 4'b1111, 32'h0,      256, 0);
`ifdef MISALIGN_CHECK_EN
    mem_txn("LWMIS", 4'b1010, 32'h0000_0101, 32'h0,       32'h1111_2222, 0, 32'h0,         0, 1, 0, 4'b1111, 32'h0,        1, 0);
    mem_txn("LHMIS", 4'b1001, 32'h0000_0103, 32'h0,       32'h8001_7FFF, 0, 32'h0,         0, 1, 0, 4'b1100, 32'h0,        1, 0);
`else
    mem_txn("LWMIS", 4'b1010, 32'h0000_0101, 32'h0,       32'h1111_2222, 0, 32'h1111_2222, 1, 0, 0, 4'b1111, 32'h0,        2, 0);
    mem_txn("LHMIS", 4'b1001, 32'h0000_0103, 32'h0,       32'h8001_7FFF, 0, 32'hFFFF_8001, 1, 0, 0, 4'b1100, 32'h0,        2, 0);
`endif

    // reset in the middle of BUSY, then a late ack that must be ignored
    @(posedge clk); #1;
    mem_op = 4'b1010; mem_reg_wdata = 32'h0000_0300; mem_we = 1'b1; bus_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rstbusy pre bus_req", {31'b0, bus_req}, 32'd1);
    rst = 1'b0; mem_op = '0; mem_we = 1'b0; mem_reg_wdata = '0; mem_reg_waddr = '0;
    #1;
    chk("rstbusy bus_req", {31'b0, bus_req}, 32'd0);
    chk("rstbusy bus_addr", bus_addr, 32'd0);
    chk("rstbusy bus_sel", {28'b0, bus_sel}, 32'd0);
    chk("rstbusy stallreq", {31'b0, stallreq_mem}, 32'd0);
    chk("rstbusy wb_wdata", wb_reg_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; bus_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("lateack%0d bus_req", i), {31'b0, bus_req}, 32'd0);
      chk($sformatf("lateack%0d stallreq", i), {31'b0, stallreq_mem}, 32'd0);
      chk($sformatf("lateack%0d mem_err", i), {31'b0, mem_err}, 32'd0);
      chk($sformatf("lateack%0d wb_we", i), {31'b0, wb_we}, 32'd0);
    end
    bus_ack = 1'b0;

    // normal operation resumes after the abandoned access
    mem_txn("LBpost", 4'b1000, 32'h0000_0400, 32'h0, 32'h0000_007F, 0, 32'h0000_007F, 1, 0, 0, 4'b0001, 32'h0, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
